// File: rtl/keypad_pkg.sv
// Shared types and sizes for the 4x4 keypad scan controller.
// Key codes are {column[1:0], row[1:0]}, which equals the snapshot bit index.
package keypad_pkg;

    localparam int KP_ROWS   = 4;
    localparam int KP_COLS   = 4;
    localparam int KP_CODE_W = 4;
    localparam int KP_KEYS   = KP_ROWS * KP_COLS;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        RELEASE_DB
    } kp_state_t;

    typedef enum logic [1:0] {
        NONE,
        SINGLE,
        MULTI
    } kp_class_t;

endpackage

// File: rtl/keypad_snapshot_eval.sv
// Classifies a full 16-bit keypad snapshot as NONE, SINGLE(code) or MULTI.
// Ghost patterns always involve at least two set bits, so they fall into MULTI.
module keypad_snapshot_eval
    import keypad_pkg::*;
(
    input  logic [KP_KEYS-1:0]   snapshot,
    output kp_class_t            key_class,
    output logic [KP_CODE_W-1:0] key_code
);

    logic [4:0] ones;

    always_comb begin
        ones     = '0;
        key_code = '0;
        for (int i = 0; i < KP_KEYS; i++) begin
            if (snapshot[i]) begin
                ones     = ones + 5'd1;
                key_code = KP_CODE_W'(i);
            end
        end
        if (ones == 5'd0) begin
            key_class = NONE;
        end else if (ones == 5'd1) begin
            key_class = SINGLE;
        end else begin
            key_class = MULTI;
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Column-scanning keypad controller with whole-matrix debounce and a valid/ready key output.
// Define KEYPAD_AUTOREPEAT_EN to re-emit a held key every REPEAT_SCANS matching scans.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1024,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [KP_ROWS-1:0]   row_in,
    output logic [KP_COLS-1:0]   col_out,
    output logic [KP_CODE_W-1:0] key_code,
    output logic                 key_valid,
    input  logic                 key_ready,
    output logic                 key_held,
    output logic                 overrun
);

    localparam int               DIV_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]       DB_LAST  = 4'(DEBOUNCE_SCANS);

    if (SCAN_DIV < 2 || DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15 ||
        REPEAT_SCANS < 1 || REPEAT_SCANS > 255) begin : g_bad_cfg
        $error("keypad_scan_ctrl: parameter out of range");
    end

    logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
    logic [1:0]           col_idx_q, col_idx_d;
    logic [KP_COLS-1:0]   col_out_q, col_out_d;
    logic [KP_KEYS-1:0]   snap_q, snap_d;
    logic                 eval_q, eval_d;
    kp_state_t            state_q, state_d;
    logic [3:0]           count_q, count_d;
    logic [KP_CODE_W-1:0] cand_q, cand_d;
    logic [KP_CODE_W-1:0] key_code_q, key_code_d;
    logic                 key_valid_q, key_valid_d;
    logic                 key_held_q, key_held_d;
    logic                 overrun_q, overrun_d;

    kp_class_t            ev_class;
    logic [KP_CODE_W-1:0] ev_code;
    logic                 press_accept, rep_accept, accept, enter_held, handshake;

    keypad_snapshot_eval u_eval (
        .snapshot  (snap_q),
        .key_class (ev_class),
        .key_code  (ev_code)
    );

    // Rows are sampled on the last divider cycle of each column; the full matrix is judged one cycle after column 3.
    always_comb begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
        col_idx_d = col_idx_q;
        snap_d    = snap_q;
        eval_d    = 1'b0;
        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            col_idx_d = col_idx_q + 2'd1;
            snap_d[{col_idx_q, 2'b00} +: KP_ROWS] = row_in;
            eval_d    = (col_idx_q == 2'd3);
        end
        col_out_d = 4'b0001 << col_idx_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q   <= '0;
            col_idx_q   <= '0;
            col_out_q   <= 4'b0001;
            snap_q      <= '0;
            eval_q      <= 1'b0;
            state_q     <= IDLE;
            count_q     <= '0;
            cand_q      <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            col_idx_q   <= col_idx_d;
            col_out_q   <= col_out_d;
            snap_q      <= snap_d;
            eval_q      <= eval_d;
            state_q     <= state_d;
            count_q     <= count_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        cand_d       = cand_q;
        press_accept = 1'b0;
        enter_held   = 1'b0;
        if (eval_q) begin
            case (state_q)
                IDLE: begin
                    if (ev_class == SINGLE) begin
                        cand_d  = ev_code;
                        count_d = 4'd1;
                        if (DB_LAST == 4'd1) begin
                            state_d      = HELD;
                            press_accept = 1'b1;
                            enter_held   = 1'b1;
                        end else begin
                            state_d = PRESS_DB;
                        end
                    end
                end
                PRESS_DB: begin
                    if (ev_class == SINGLE && ev_code == cand_q) begin
                        count_d = count_q + 4'd1;
                        if (count_d == DB_LAST) begin
                            state_d      = HELD;
                            press_accept = 1'b1;
                            enter_held   = 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                        count_d = '0;
                    end
                end
                HELD: begin
                    if (ev_class == NONE) begin
                        count_d = 4'd1;
                        state_d = (DB_LAST == 4'd1) ? IDLE : RELEASE_DB;
                    end
                end
                RELEASE_DB: begin
                    if (ev_class == NONE) begin
                        count_d = count_q + 4'd1;
                        if (count_d == DB_LAST) begin
                            state_d = IDLE;
                            count_d = '0;
                        end
                    end else begin
                        state_d = HELD;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam logic [7:0] REP_LAST = 8'(REPEAT_SCANS);

    logic [7:0] rep_cnt_q, rep_cnt_d;

    // Only evaluations made while already HELD count, so a bounce through RELEASE_DB keeps the tally.
    always_comb begin
        rep_cnt_d  = rep_cnt_q;
        rep_accept = 1'b0;
        if (enter_held) begin
            rep_cnt_d = '0;
        end else if (eval_q && state_q == HELD && ev_class == SINGLE && ev_code == cand_q) begin
            rep_cnt_d = rep_cnt_q + 8'd1;
            if (rep_cnt_d == REP_LAST) begin
                rep_cnt_d  = '0;
                rep_accept = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt_q <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
        end
    end
`else
    assign rep_accept = 1'b0;
`endif

    assign accept = press_accept | rep_accept;

    // A handshake in the accept cycle frees the slot, so the new key loads instead of overrunning.
    always_comb begin
        handshake   = key_valid_q & key_ready;
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q & ~handshake;
        overrun_d   = 1'b0;
        if (accept) begin
            if (!key_valid_q || handshake) begin
                key_code_d  = cand_d;
                key_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
        key_held_d = (state_d == HELD);
    end

    assign col_out   = col_out_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl: directed vector table, corner sequences and random scans
// compared every cycle against a scan-level reference model (autorepeat expectations follow KEYPAD_AUTOREPEAT_EN).
module tb_keypad_scan_ctrl;

    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_SCANS = 3;
    localparam int REPEAT_SCANS   = 2;
    localparam int PERIOD         = 4 * SCAN_DIV;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam bit AUTOREPEAT = 1'b1;
`else
    localparam bit AUTOREPEAT = 1'b0;
`endif

    typedef struct {
        logic [15:0] mask;
        bit          valid;
        logic [3:0]  code;
        bit          held;
    } kp_vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready = 1'b1;
    logic        key_held;
    logic        overrun;
    logic [15:0] key_mask = '0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit rand_ready = 1'b0;

    bit          m_valid, m_ovr, m_held;
    logic [3:0]  m_code, m_col, cand;
    logic [15:0] scan_cap;
    int          press_run, rel_run, rep_run;

    kp_vec_t vecs[$];

    keypad_scan_ctrl #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
        .REPEAT_SCANS   (REPEAT_SCANS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_held  (key_held),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key connects its column drive to its row.
    always_comb begin
        row_in = '0;
        for (int c = 0; c < 4; c++) begin
            if (col_out[c]) row_in = row_in | key_mask[4*c +: 4];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic modelReset();
        m_valid = 0; m_ovr = 0; m_held = 0;
        m_code = '0; m_col = 4'b0001; cand = '0; scan_cap = '0;
        press_run = 0; rel_run = 0; rep_run = 0;
    endtask

    // Applies the press/release/repeat rules to one complete scan.
    task automatic evalScan(input logic [15:0] mask, output bit acc, output logic [3:0] acode);
        int n;
        bit none, single;
        logic [3:0] k;
        n = $countones(mask);
        none = (n == 0);
        single = (n == 1);
        k = single ? 4'($clog2(mask)) : 4'd0;
        acc = 0;
        acode = cand;
        if (!m_held) begin
            if (press_run == 0) begin
                if (single) begin cand = k; press_run = 1; end
            end else if (single && k == cand) begin
                press_run++;
            end else begin
                press_run = 0;
            end
            if (press_run == DEBOUNCE_SCANS) begin
                acc = 1; acode = cand; m_held = 1;
                press_run = 0; rel_run = 0; rep_run = 0;
            end
        end else if (none) begin
            rel_run++;
            if (rel_run == DEBOUNCE_SCANS) begin m_held = 0; rel_run = 0; end
        end else begin
            if (rel_run == 0 && single && k == cand) begin
                rep_run++;
                if (AUTOREPEAT && rep_run == REPEAT_SCANS) begin acc = 1; acode = cand; rep_run = 0; end
            end
            rel_run = 0;
        end
    endtask

    task automatic modelStep();
        bit hs, acc;
        logic [3:0] acode;
        hs = m_valid && key_ready;
        acc = 0;
        acode = '0;
        if (cyc > 1 && cyc % PERIOD == 1) evalScan(scan_cap, acc, acode);
        m_ovr = 0;
        if (acc) begin
            if (!m_valid || hs) begin m_valid = 1; m_code = acode; end
            else m_ovr = 1;
        end else if (hs) begin
            m_valid = 0;
        end
        if (cyc % PERIOD == 0) scan_cap = key_mask;
        m_col = 4'b0001 << ((cyc / SCAN_DIV) % 4);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        modelStep();
        #1;
        checkOutput("col_out", col_out, m_col);
        checkOutput("key_valid", key_valid, m_valid);
        checkOutput("key_code", key_code, m_code);
        checkOutput("key_held", key_held, m_held && rel_run == 0);
        checkOutput("overrun", overrun, m_ovr);
        if (rand_ready) key_ready = 1'($urandom_range(0, 1));
    endtask

    // One full scan with a fixed set of pressed keys, ending just after its evaluation lands.
    task automatic applyStimulus(input logic [15:0] mask);
        key_mask = mask;
        repeat (PERIOD) tick();
    endtask

    task automatic doReset();
        rst = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            checkOutput("rst_col_out", col_out, 4'b0001);
            checkOutput("rst_key_valid", key_valid, 0);
            checkOutput("rst_key_code", key_code, 0);
            checkOutput("rst_key_held", key_held, 0);
            checkOutput("rst_overrun", overrun, 0);
        end
        key_mask = '0;
        rst = 1'b0;
        modelReset();
        cyc = 0;
        tick();
    endtask

    function automatic void addVec(input logic [15:0] mask, input int n, input bit valid,
                                   input logic [3:0] code, input bit held);
        kp_vec_t v;
        v.mask = mask; v.valid = valid; v.code = code; v.held = held;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    initial begin
        bit exp_rep;
        logic [15:0] rmask;

        // Clean press of code 6, bounce, two-key chord then a single key, ghost rectangle.
        addVec(16'h0040, 2, 0, 4'h0, 0); addVec(16'h0040, 1, 1, 4'h6, 1);
        addVec(16'h0040, 1, 0, 4'h0, 1); addVec(16'h0000, 3, 0, 4'h0, 0);
        addVec(16'h0040, 2, 0, 4'h0, 0); addVec(16'h0000, 1, 0, 4'h0, 0);
        addVec(16'h0040, 2, 0, 4'h0, 0); addVec(16'h0040, 1, 1, 4'h6, 1);
        addVec(16'h0000, 3, 0, 4'h0, 0);
        addVec(16'h0021, 10, 0, 4'h0, 0); addVec(16'h0000, 1, 0, 4'h0, 0);
        addVec(16'h0020, 2, 0, 4'h0, 0); addVec(16'h0020, 1, 1, 4'h5, 1);
        addVec(16'h0000, 3, 0, 4'h0, 0);
        addVec(16'h0013, 4, 0, 4'h0, 0); addVec(16'h0000, 1, 0, 4'h0, 0);

        modelReset();
        doReset();

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].mask);
            checkOutput($sformatf("vec%0d_valid", i), key_valid, vecs[i].valid);
            if (vecs[i].valid) checkOutput($sformatf("vec%0d_code", i), key_code, vecs[i].code);
            checkOutput($sformatf("vec%0d_held", i), key_held, vecs[i].held);
        end

        // Overrun: key 3 stays pending while key 9 is accepted.
        key_ready = 1'b0;
        repeat (3) applyStimulus(16'h0008);
        checkOutput("ovr_first_valid", key_valid, 1);
        checkOutput("ovr_first_code", key_code, 4'h3);
        repeat (3) applyStimulus(16'h0000);
        repeat (2) applyStimulus(16'h0200);
        checkOutput("ovr_before_third", overrun, 0);
        applyStimulus(16'h0200);
        checkOutput("ovr_pulse", overrun, 1);
        checkOutput("ovr_code_kept", key_code, 4'h3);
        checkOutput("ovr_valid_kept", key_valid, 1);
        tick();
        checkOutput("ovr_pulse_once", overrun, 0);
        key_ready = 1'b1;
        tick();
        checkOutput("ovr_valid_drop", key_valid, 0);
        while (cyc % PERIOD != 1) tick();
        repeat (3) applyStimulus(16'h0000);

        // Holding key F: repeats only when autorepeat is built in.
        for (int s = 1; s <= 9; s++) begin
            applyStimulus(16'h8000);
            exp_rep = (s == 3) || (AUTOREPEAT && s > 3 && (s - 3) % REPEAT_SCANS == 0);
            checkOutput($sformatf("rep_scan%0d_valid", s), key_valid, exp_rep);
            if (exp_rep) checkOutput($sformatf("rep_scan%0d_code", s), key_code, 4'hF);
        end
        repeat (3) applyStimulus(16'h0000);

        // Random key activity with a randomly stalling consumer.
        rand_ready = 1'b1;
        rmask = '0;
        for (int s = 0; s < 60; s++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: ;
                4, 5:       rmask = '0;
                6, 7, 8:    rmask = 16'h0001 << $urandom_range(0, 15);
                default:    rmask = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            endcase
            applyStimulus(rmask);
        end
        rand_ready = 1'b0;
        key_ready = 1'b1;

        // Reset in the middle of a scan with an undelivered key.
        key_ready = 1'b0;
        repeat (3) applyStimulus(16'h0100);
        checkOutput("midrst_pending", key_valid, 1);
        repeat (5) tick();
        doReset();
        key_ready = 1'b1;
        repeat (3) applyStimulus(16'h0004);
        checkOutput("post_rst_valid", key_valid, 1);
        checkOutput("post_rst_code", key_code, 4'h2);
        repeat (3) applyStimulus(16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

Scan controller for the 4x4 calculator keypad. It drives one keypad column at a time, samples the four row inputs, and debounces whole-matrix snapshots. Each debounced single-key press is delivered as a 4-bit key code over a valid/ready handshake to the calculator core. It sits between the chip-level row inputs and column outputs and the calculator datapath, replacing ad-hoc scanning inside the core.

## Interface
- `SCAN_DIV`, default 1024: clock cycles each column is driven; must be ≥ 2.
- `DEBOUNCE_SCANS`, default 4: consecutive identical full-matrix scans needed to accept a press or a release; range 1–15.
- `REPEAT_SCANS`, default 32: scans between auto-repeat emissions; only used with `KEYPAD_AUTOREPEAT_EN`; range 1–255.
- `clk` in 1: single clock for the block.
- `rst` in 1: reset, asynchronous and active-high.
- `row_in` in 4: keypad rows, active-high; bit r is row r.
- `col_out` out 4: one-hot active-high column drive; bit c is column c.
- `key_code` out 4: accepted key, {column[1:0], row[1:0]}.
- `key_valid` out 1: `key_code` holds an undelivered key.
- `key_ready` in 1: consumer accepts the key when `key_valid` and `key_ready` are both high.
- `key_held` out 1: a debounced key is currently down.
- `overrun` out 1: one-cycle pulse when an accepted key is dropped because `key_valid` was still pending.

## Operation
- Column counter `col_idx` (0..3) and divider counter `div_cnt` (0..SCAN_DIV-1).
  - `col_out` = 1<<`col_idx`.
  - When `div_cnt` = SCAN_DIV-1, `row_in` is sampled into snapshot bits [4*col_idx+3 : 4*col_idx], then `col_idx` increments and wraps 3→0.
- Scan complete: the cycle in which column 3 is sampled. The full 16-bit snapshot is evaluated on the next cycle.
- Evaluation classes:
  - NONE: zero bits set.
  - SINGLE(code): exactly one bit set.
  - MULTI: two or more bits set, or a ghost pattern. MULTI is treated as NONE for press detection and does not count toward release.
- State machine `IDLE → PRESS_DB → HELD → RELEASE_DB → IDLE`.
  - IDLE: SINGLE(k) loads candidate = k, sets count = 1, and goes to PRESS_DB. If DEBOUNCE_SCANS = 1, it accepts immediately and goes to HELD.
  - PRESS_DB: SINGLE(same k) increments count. When count reaches DEBOUNCE_SCANS, the key is accepted and the state goes to HELD. Any other class returns to IDLE.
  - HELD: `key_held` = 1. NONE sets count = 1 and goes to RELEASE_DB. SINGLE(k) and MULTI stay in HELD; a different key arriving while one is held is ignored.
  - RELEASE_DB: NONE increments count. When count reaches DEBOUNCE_SCANS, the state goes to IDLE. Any non-NONE class returns to HELD.
- Accept:
  - If `key_valid` = 0: `key_code` ← k and `key_valid` ← 1.
  - Otherwise: `key_code` is unchanged and `overrun` pulses.
- Handshake:
  - `key_valid` falls the cycle after a handshake.
  - `key_code` is stable while `key_valid` is high.
  - An accept and a handshake in the same cycle: the handshake completes and the new key loads. `key_valid` stays 1 and no overrun occurs.
- `key_ready` high while `key_valid` is low has no effect.

## Timing
- Reset values:
  - `col_out` = 4'b0001, `col_idx` = 0, `div_cnt` = 0, snapshot = 0.
  - State IDLE, count = 0.
  - `key_code` = 0, `key_valid` = 0, `key_held` = 0, `overrun` = 0.
- Reset mid-operation aborts the scan and any pending key. The first post-reset sample occurs SCAN_DIV cycles after `rst` falls.
- Scan period = 4·SCAN_DIV cycles. Rows are sampled SCAN_DIV-1 cycles after a column is asserted, which gives settling time.
- Press latency: `key_valid` rises 1 cycle after the evaluation of the DEBOUNCE_SCANS-th consistent scan. That evaluation is itself 1 cycle after the column-3 sample.
- `key_held` changes in the same cycle as the state transition.
- All outputs are registered. There is no combinational path from `key_ready` or `row_in` to any output.

## Configuration
- `KEYPAD_AUTOREPEAT_EN` defined:
  - In HELD, a repeat counter counts SINGLE(held key) evaluations. Every REPEAT_SCANS of them, the held key is accepted again through the same accept/overrun rules.
  - The counter clears on entry to HELD.
  - RELEASE_DB → HELD does not clear the counter.
- Not defined: exactly one emission per press, and no repeat counter logic is synthesized.

## Structure
- Package `keypad_pkg`:
  - State enum `kp_state_t` (IDLE, PRESS_DB, HELD, RELEASE_DB).
  - `KP_ROWS` = 4, `KP_COLS` = 4, `KP_CODE_W` = 4.
  - Class enum (NONE, SINGLE, MULTI).
- Sub-module `keypad_snapshot_eval`: combinational; takes the 16-bit snapshot and returns class and code.
- Top `keypad_scan_ctrl` holds the timer, column counter, FSM and output register.

## Test plan
Bench parameters are SCAN_DIV = 4, DEBOUNCE_SCANS = 3, and `key_ready` is held high unless stated otherwise.
- Reset: hold `rst` for 5 cycles, then release. Required: `col_out` = 0001, and it steps 0010/0100/1000/0001 every 4 cycles; `key_valid` = 0.
- Clean press: row 2 is high only while column 1 is driven, for 3 scans. Required: one `key_valid` pulse with `key_code` = 4'b0110, 1 cycle after the 3rd evaluation; `key_held` = 1; no further valid while the key is held.
- Bounce: the key is present in scans 1 and 2, absent in scan 3, then present in 3 more scans. Required: no emission until the 6th scan's evaluation.
- Two keys (code 0 and code 5) pressed together for 10 scans. Required: no emission. Release both, then press code 5 alone for 3 scans. Required: `key_code` = 5.
- Overrun: `key_ready` = 0; press and release key 3, then press key 9. Required: `key_code` stays 3 and `overrun` pulses once. After raising `key_ready`, `key_valid` drops the next cycle.
- Autorepeat (macro on, REPEAT_SCANS = 2): hold key 0xF for 9 scans. Required: emissions at scan 3, then at scans 5, 7 and 9.
